// File: rtl/jp_pkg.sv
// ----------------------------------------------------------------------------
// jp_pkg : button bit indices and helpers shared by the emulated NES pad.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jp_pkg;

  localparam int JP_BTN_W  = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef logic [JP_BTN_W-1:0] btn_t;

  // Forces A/B to released when the auto-fire phase is in its "off" half.
  function automatic btn_t turbo_filter(input btn_t value, input logic [1:0] mask,
                                        input logic phase);
    btn_t clr;
    clr        = '0;
    clr[BTN_A] = mask[0];
    clr[BTN_B] = mask[1];
    return phase ? (value & ~clr) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jp_sync.sv
// ----------------------------------------------------------------------------
// jp_sync : multi-flop synchronizer with synced level and rising-edge pulse.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

`default_nettype wire

// File: rtl/jp_pad_emu.sv
// ----------------------------------------------------------------------------
// jp_pad_emu : emulated 4021-style NES pad driven by host-written button state.
// Optional auto-fire on A/B enabled by defining TURBO_PAD_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jp_pad_emu
  import jp_pkg::*;
#(
  parameter int SYNC_STAGES   = 2
`ifdef TURBO_PAD_EN
  , parameter int TURBO_LATCHES = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_wr,
  input  logic [JP_BTN_W-1:0] btn_din,
  input  logic                jp_latch,
  input  logic                jp_clk,
`ifdef TURBO_PAD_EN
  input  logic [1:0]          turbo_mask,
`endif
  output logic                jp_data,
  output logic [JP_BTN_W-1:0] btn_state,
  output logic [15:0]         latch_cnt
);

  logic latch_lvl;
  logic latch_rise;
  logic clk_lvl;
  logic clk_rise;
  btn_t pending;
  btn_t shift;
  btn_t shift_nx;
  btn_t raw_load;
  btn_t load_val;

  jp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (jp_latch),
    .level (latch_lvl),
    .rise  (latch_rise)
  );

  jp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (jp_clk),
    .level (clk_lvl),
    .rise  (clk_rise)
  );

  // A write coinciding with a load is bypassed so the new state is seen immediately.
  assign raw_load = btn_wr ? btn_din : pending;

`ifdef TURBO_PAD_EN
  logic [15:0] turbo_cnt;
  logic        phase;
  logic        load_phase;

  // Reloads while latch stays high reuse the phase captured at the rising edge.
  assign load_val = turbo_filter(raw_load, turbo_mask, latch_rise ? phase : load_phase);

  always_ff @(posedge clk) begin
    if (rst) begin
      turbo_cnt  <= '0;
      phase      <= 1'b0;
      load_phase <= 1'b0;
    end else if (latch_rise) begin
      load_phase <= phase;
      if (turbo_cnt == 16'(TURBO_LATCHES - 1)) begin
        turbo_cnt <= '0;
        phase     <= ~phase;
      end else begin
        turbo_cnt <= turbo_cnt + 16'd1;
      end
    end
  end
`else
  assign load_val = raw_load;
`endif

  always_comb begin
    shift_nx = shift;
    if (latch_lvl) begin
      shift_nx = load_val;
    end else if (clk_rise && clk_lvl) begin
      shift_nx = {1'b0, shift[JP_BTN_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      shift     <= '0;
      jp_data   <= 1'b1;
      latch_cnt <= '0;
    end else begin
      if (btn_wr) begin
        pending <= btn_din;
      end
      shift   <= shift_nx;
      jp_data <= ~shift_nx[0];
      if (latch_rise) begin
        latch_cnt <= latch_cnt + 16'd1;
      end
    end
  end

  assign btn_state = pending;

endmodule

`default_nettype wire
